// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, constants and FSM state type used by the
// write port and the VGA scan-out side.
package fb_pkg;

    localparam int FB_WIDTH  = 240;
    localparam int FB_HEIGHT = 160;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 16;

    // Colour shown by scan-out outside the visible frame.
    localparam logic [14:0] FB_GREY = 15'b110111101111011;

    // Bit 15 of incoming pixels is not part of BGR555 and is stored as 0.
    localparam logic [15:0] FB_DATA_MASK = 16'h7FFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_WRITE   = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Column/row/base counters producing the linear frame-buffer address
// row*WIDTH + col without a multiplier.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    output logic [FB_ADDR_W-1:0] addr,
    output logic                 last
);

    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [FB_ADDR_W-1:0] base;
    logic                 col_last;
    logic                 row_last;

    assign col_last = (col == COL_W'(WIDTH - 1));
    assign row_last = (row == ROW_W'(HEIGHT - 1));
    assign last     = col_last & row_last;
    assign addr     = base + FB_ADDR_W'(col);

    // Clear wins over advance so the final pixel never pushes base past the last row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            base <= '0;
        end else if (clear) begin
            col  <= '0;
            row  <= '0;
            base <= '0;
        end else if (advance) begin
            if (col_last) begin
                col  <= '0;
                row  <= row + 1'b1;
                base <= base + FB_ADDR_W'(WIDTH);
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Frame-buffer write port: accepts a valid/ready pixel stream and issues
// registered linear writes, optionally starting each frame on a vsync edge.
module fb_writer
    import fb_pkg::*;
#(
    parameter int   WIDTH      = FB_WIDTH,
    parameter int   HEIGHT     = FB_HEIGHT,
    parameter logic SYNC_TO_VS = 1'b1,
    parameter logic VS_ACTIVE  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    input  logic        vs,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        restart_err
);

    localparam fb_state_t START_STATE = SYNC_TO_VS ? ST_WAIT_VS : ST_WRITE;

    fb_state_t            state;
    fb_state_t            next_state;
    logic                 vs_q;
    logic                 vs_edge;
    logic                 hs;
    logic                 last;
    logic                 frame_end;
    logic                 restart_pulse;
    logic [FB_ADDR_W-1:0] addr;

    assign pix_ready     = (state == ST_WRITE);
    assign busy          = (state != ST_IDLE);
    assign hs            = pix_valid & pix_ready;
    assign frame_end     = hs & last;
    assign vs_edge       = (vs == VS_ACTIVE) && (vs_q != VS_ACTIVE);
    assign restart_pulse = frame_start & busy & ~frame_end;

    fb_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (frame_start | frame_end),
        .advance (hs),
        .addr    (addr),
        .last    (last)
    );

    // A new frame_start always takes precedence over the current state.
    always_comb begin
        next_state = state;
        if (frame_start) begin
            next_state = START_STATE;
        end else begin
            case (state)
                ST_WAIT_VS: if (vs_edge)   next_state = ST_WRITE;
                ST_WRITE:   if (frame_end) next_state = ST_IDLE;
                default:    next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            vs_q        <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            restart_err <= 1'b0;
        end else begin
            state       <= next_state;
            vs_q        <= vs;
            wr_en       <= hs;
            frame_done  <= frame_end;
            restart_err <= restart_pulse;
            if (hs) begin
                wr_addr <= addr;
                wr_data <= pix_data & FB_DATA_MASK;
            end
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: two instances (free-running and vsync-locked) driven
// with random pixel streams and compared every cycle to a linear-index model.
module tb_fb_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, fs_a = 1'b0, valid_a = 1'b0, vs_a = 1'b1;
    logic [15:0] data_a = '0;
    logic        ready_a, wr_en_a, busy_a, done_a, rerr_a;
    logic [15:0] wr_addr_a, wr_data_a;

    logic        rst_b = 1'b1, fs_b = 1'b0, valid_b = 1'b0, vs_b = 1'b0;
    logic [15:0] data_b = '0;
    logic        ready_b, wr_en_b, busy_b, done_b, rerr_b;
    logic [15:0] wr_addr_b, wr_data_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int writes_b     = 0;

    fb_writer #(.WIDTH(240), .HEIGHT(160), .SYNC_TO_VS(1'b0), .VS_ACTIVE(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .frame_start(fs_a), .pix_valid(valid_a), .pix_data(data_a),
        .pix_ready(ready_a), .vs(vs_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .busy(busy_a), .frame_done(done_a), .restart_err(rerr_a)
    );

    fb_writer #(.WIDTH(240), .HEIGHT(160), .SYNC_TO_VS(1'b1), .VS_ACTIVE(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .frame_start(fs_b), .pix_valid(valid_b), .pix_data(data_b),
        .pix_ready(ready_b), .vs(vs_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .busy(busy_b), .frame_done(done_b), .restart_err(rerr_b)
    );

    // Model: phase 0 idle, 1 waiting for vsync, 2 accepting; idx is the linear pixel index.
    typedef struct {
        int phase;
        int idx;
        bit vs_prev;
        bit wr_en;
        int addr;
        int data;
        bit done;
        bit rerr;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.phase = 0; m.idx = 0; m.vs_prev = 1'b0;
        m.wr_en = 1'b0; m.addr = 0; m.data = 0; m.done = 1'b0; m.rerr = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input bit fs, input bit valid,
                                          input logic [15:0] data, input bit vs, input bit sync);
        model_t n;
        bit     hs;
        bit     last;
        n    = m;
        hs   = valid && (m.phase == 2);
        last = hs && (m.idx == 240 * 160 - 1);
        n.wr_en = hs;
        if (hs) begin
            n.addr = m.idx;
            n.data = int'(data & 16'h7FFF);
        end
        n.done = last;
        n.rerr = fs && (m.phase != 0) && !last;
        if (fs) begin
            n.phase = sync ? 1 : 2;
            n.idx   = 0;
        end else if (m.phase == 1) begin
            if (vs == 1'b0 && m.vs_prev == 1'b1) n.phase = 2;
        end else if (hs) begin
            if (last) begin
                n.phase = 0;
                n.idx   = 0;
            end else begin
                n.idx = m.idx + 1;
            end
        end
        n.vs_prev = vs;
        return n;
    endfunction

    model_t ma, mb;

    always @(posedge clk or posedge rst_a)
        if (rst_a) ma <= model_reset();
        else       ma <= model_step(ma, fs_a, valid_a, data_a, vs_a, 1'b0);

    always @(posedge clk or posedge rst_b)
        if (rst_b) mb <= model_reset();
        else       mb <= model_step(mb, fs_b, valid_b, data_b, vs_b, 1'b1);

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic compareDut(input string tag, input model_t m, input logic en,
                              input logic [15:0] addr, input logic [15:0] data,
                              input logic done, input logic rerr,
                              input logic busy, input logic ready);
        checkOutput({tag, ".wr_en"}, int'(en), int'(m.wr_en));
        if (m.wr_en) begin
            checkOutput({tag, ".wr_addr"}, int'(addr), m.addr);
            checkOutput({tag, ".wr_data"}, int'(data), m.data);
        end
        checkOutput({tag, ".frame_done"}, int'(done), int'(m.done));
        checkOutput({tag, ".restart_err"}, int'(rerr), int'(m.rerr));
        checkOutput({tag, ".busy"}, int'(busy), int'(m.phase != 0));
        checkOutput({tag, ".pix_ready"}, int'(ready), int'(m.phase == 2));
    endtask

    always @(negedge clk) begin
        if (!rst_a) compareDut("a", ma, wr_en_a, wr_addr_a, wr_data_a, done_a, rerr_a, busy_a, ready_a);
        if (!rst_b) compareDut("b", mb, wr_en_b, wr_addr_b, wr_data_b, done_b, rerr_b, busy_b, ready_b);
        if (!rst_b && wr_en_b) writes_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit which, input bit fs, input bit valid,
                                 input logic [15:0] data, input bit vs);
        if (!which) begin
            fs_a = fs; valid_a = valid; data_a = data; vs_a = vs;
        end else begin
            fs_b = fs; valid_b = valid; data_b = data; vs_b = vs;
        end
    endtask

    // Free-running instance: full continuous frame, mid-frame restart, async reset.
    task automatic runA();
        logic [15:0] d;
        applyStimulus(0, 0, 0, 16'h0, 1);
        repeat (3) tick();
        rst_a = 1'b0;
        tick();
        checkOutput("a.reset_busy", int'(busy_a), 0);
        checkOutput("a.reset_ready", int'(ready_a), 0);
        checkOutput("a.reset_wr_en", int'(wr_en_a), 0);
        checkOutput("a.reset_wr_addr", int'(wr_addr_a), 0);

        applyStimulus(0, 1, 0, 16'h0, 1);
        tick();
        checkOutput("a.ready_after_start", int'(ready_a), 1);

        for (int i = 0; i < 38400; i++) begin
            d = (i == 245) ? 16'hFFFF : 16'(i);
            applyStimulus(0, 0, 1, d, 1);
            tick();
            if (i == 0) begin
                checkOutput("a.first_addr", int'(wr_addr_a), 0);
                checkOutput("a.first_data", int'(wr_data_a), 0);
            end
            if (i == 239) checkOutput("a.row_end_addr", int'(wr_addr_a), 239);
            if (i == 240) checkOutput("a.row_wrap_addr", int'(wr_addr_a), 240);
            if (i == 245) begin
                checkOutput("a.r1c5_addr", int'(wr_addr_a), 245);
                checkOutput("a.r1c5_data", int'(wr_data_a), 16'h7FFF);
            end
            if (i == 38399) begin
                checkOutput("a.last_addr", int'(wr_addr_a), 16'h95FF);
                checkOutput("a.last_done", int'(done_a), 1);
                checkOutput("a.last_busy", int'(busy_a), 0);
            end
        end
        applyStimulus(0, 0, 0, 16'h0, 1);
        tick();
        checkOutput("a.idle_busy", int'(busy_a), 0);
        checkOutput("a.idle_done", int'(done_a), 0);

        applyStimulus(0, 1, 0, 16'h0, 1);
        tick();
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(0, 0, 1, 16'($urandom), 1);
            tick();
        end
        applyStimulus(0, 1, 1, 16'h2ABC, 1);
        tick();
        checkOutput("a.restart_old_addr", int'(wr_addr_a), 1000);
        checkOutput("a.restart_err", int'(rerr_a), 1);
        applyStimulus(0, 0, 1, 16'h1234, 1);
        tick();
        checkOutput("a.restart_new_addr", int'(wr_addr_a), 0);
        checkOutput("a.restart_new_data", int'(wr_data_a), 16'h1234);
        checkOutput("a.restart_err_once", int'(rerr_a), 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, ($urandom_range(0, 99) >= 30), 16'($urandom), 1);
            tick();
        end
        applyStimulus(0, 0, 1, 16'h0055, 1);
        tick();
        checkOutput("a.pre_reset_wr_en", int'(wr_en_a), 1);
        #1 rst_a = 1'b1;
        #1;
        checkOutput("a.async_wr_en", int'(wr_en_a), 0);
        checkOutput("a.async_busy", int'(busy_a), 0);
        checkOutput("a.async_ready", int'(ready_a), 0);
        tick();
        rst_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("a.post_reset_ready", int'(ready_a), 0);
            checkOutput("a.post_reset_wr_en", int'(wr_en_a), 0);
        end
        applyStimulus(0, 1, 0, 16'h0, 1);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 1);
        checkOutput("a.ready_after_restart", int'(ready_a), 1);
    endtask

    // Vsync-locked instance: edge wait, gapped full frame ending in a coincident restart.
    task automatic runB();
        int n;
        int cycles;
        bit v;
        applyStimulus(1, 0, 0, 16'h0, 0);
        repeat (3) tick();
        rst_b = 1'b0;
        tick();
        applyStimulus(1, 1, 0, 16'h0, 0);
        tick();
        applyStimulus(1, 0, 1, 16'h1111, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("b.wait_ready_low", int'(ready_b), 0);
            checkOutput("b.wait_no_write", int'(wr_en_b), 0);
        end
        applyStimulus(1, 0, 1, 16'h2222, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("b.vs_high_ready_low", int'(ready_b), 0);
        end
        applyStimulus(1, 0, 0, 16'h0, 0);
        checkOutput("b.edge_cycle_ready", int'(ready_b), 0);
        tick();
        checkOutput("b.after_edge_ready", int'(ready_b), 1);

        writes_b = 0;
        n = 0;
        cycles = 0;
        while (n < 38400 && cycles < 120000) begin
            v = ($urandom_range(0, 99) >= 30);
            applyStimulus(1, v && (n == 38399), v, 16'($urandom), 0);
            tick();
            if (v) n++;
            cycles++;
        end
        checkOutput("b.frame_finished_in_budget", n, 38400);
        checkOutput("b.final_addr", int'(wr_addr_b), 16'h95FF);
        checkOutput("b.final_done", int'(done_b), 1);
        checkOutput("b.final_no_restart_err", int'(rerr_b), 0);
        checkOutput("b.final_busy_restart", int'(busy_b), 1);
        applyStimulus(1, 0, 0, 16'h0, 0);
        tick();
        checkOutput("b.write_count", writes_b, 38400);
        checkOutput("b.new_frame_waits", int'(ready_b), 0);
        applyStimulus(1, 0, 0, 16'h0, 1);
        tick();
        applyStimulus(1, 0, 0, 16'h0, 0);
        tick();
        applyStimulus(1, 0, 1, 16'h8001, 0);
        tick();
        applyStimulus(1, 0, 0, 16'h0, 0);
        checkOutput("b.new_frame_addr", int'(wr_addr_b), 0);
        checkOutput("b.new_frame_data", int'(wr_data_b), 16'h0001);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, tests_failed=%0d", tests_failed);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        fork
            runA();
            runB();
        join
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
